// File: rtl/tacc_softreg_mailbox_pkg.sv
// tacc_mailbox_pkg
//   Shared definitions for the SoftReg mailbox: register offsets inside a
//   channel's 4-word slot, CTRL bit positions, the default empty-FIFO read
//   code, SoftReg request/response structs and the STATUS word layout.
package tacc_mailbox_pkg;

  // Register offsets within one channel slot (addr - BASE_ADDR) % 4
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL write bits
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Value returned by a DATA read of an empty role->host FIFO
  localparam logic [63:0] DEFAULT_EMPTY_CODE = 64'd110000;

  // Width of the optional push timestamp
  localparam int TS_WIDTH = 32;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } softreg_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } softreg_resp_t;

  // STATUS read word; first member is the MSB end
  typedef struct packed {
    logic [21:0] reserved;   // [63:42]
    logic        r2h_empty;  // [41]
    logic        h2r_full;   // [40]
    logic [7:0]  ovf_count;  // [39:32]
    logic [15:0] h2r_occ;    // [31:16]
    logic [15:0] r2h_occ;    // [15:0]
  } status_t;

  // Overflow counter increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tacc_softreg_mailbox_if.sv
// tacc_softreg_mailbox_if
//   SoftReg bus bundle between the host shell and the mailbox.
//   rx : host request  (valid, is_write, addr[31:0], data[63:0])
//   tx : host response (valid, data[63:0])
//   master modport = host side, slave modport = mailbox side.
interface tacc_softreg_mailbox_if;
  import tacc_mailbox_pkg::*;

  softreg_req_t  rx;
  softreg_resp_t tx;

  modport master (output rx, input tx);
  modport slave  (input rx, output tx);

endinterface

// File: rtl/tacc_softreg_mailbox_fifo.sv
// tacc_sync_fifo
//   Single-clock first-word-fall-through FIFO, 2**DEPTH_LOG2 entries.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     wr, din   - push request and data (ignored while full)
//     rd        - pop request (ignored while empty)
//     flush     - empties the FIFO; wins over a same-cycle push/pop
//     dout      - head word, valid whenever !empty
//     empty     - no entries
//     full      - 2**DEPTH_LOG2 entries
//     count     - occupancy, DEPTH_LOG2+1 bits so a full FIFO reads DEPTH
module tacc_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                rd,
  input  logic                flush,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  // A push while full is refused even if a pop frees a slot this cycle
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; contents are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tacc_softreg_mailbox.sv
// tacc_softreg_mailbox
//   Multi-channel host<->role mailbox on the SoftReg bus. Each of NUM_CH
//   channels has a host->role and a role->host FIFO (DATA_WIDTH wide,
//   2**DEPTH_LOG2 deep). The window BASE_ADDR .. BASE_ADDR+4*NUM_CH-1 maps
//   per channel: +0 DATA, +1 STATUS, +2 CTRL, +3 reserved. Every mapped read
//   answers on tx exactly two cycles after the request; one request per cycle.
//   Ports:
//     clk, rst         - clock, synchronous active-high reset
//     sr (slave)       - SoftReg request rx / response tx
//     to_host_valid    - per channel, role offers a word
//     to_host_ready    - per channel, role->host FIFO not full
//     to_host_data     - channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//     from_host_valid  - per channel, host->role FIFO not empty
//     from_host_ready  - per channel, role consumes head word
//     from_host_data   - per channel head word (first-word-fall-through)
//     irq_pending      - per channel, role->host FIFO not empty
//   Optional build macro TACC_MAILBOX_TIMESTAMP_EN: stores a 32-bit cycle
//   stamp with each role->host push and returns it in DATA read bits [63:32].
module tacc_softreg_mailbox
  import tacc_mailbox_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH_LOG2 = 5,
  parameter logic [31:0] BASE_ADDR  = 32'd1234,
  parameter logic [63:0] EMPTY_CODE = DEFAULT_EMPTY_CODE
) (
  input  logic                           clk,
  input  logic                           rst,
  tacc_softreg_mailbox_if.slave          sr,
  input  logic [NUM_CH-1:0]              to_host_valid,
  output logic [NUM_CH-1:0]              to_host_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   to_host_data,
  output logic [NUM_CH-1:0]              from_host_valid,
  input  logic [NUM_CH-1:0]              from_host_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   from_host_data,
  output logic [NUM_CH-1:0]              irq_pending
);

  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [31:0] WIN_SIZE = 32'(4 * NUM_CH);
`ifdef TACC_MAILBOX_TIMESTAMP_EN
  localparam int          R2H_W    = DATA_WIDTH + TS_WIDTH;
`else
  localparam int          R2H_W    = DATA_WIDTH;
`endif

`ifdef TACC_MAILBOX_TIMESTAMP_EN
  // The stamp occupies the upper half of the read word, so data must fit below it
  if (DATA_WIDTH > 32) begin : g_ts_width_check
    $error("tacc_softreg_mailbox: DATA_WIDTH must be <= 32 with timestamps enabled");
  end

  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // Address decode. Addresses below BASE_ADDR wrap to huge offsets and
  // therefore fall outside the window as well.
  logic [31:0]     off;
  logic            in_win;
  logic            req_rd;
  logic            req_wr;
  logic [CH_W-1:0] ch;
  logic [1:0]      reg_sel;
  logic            unused_bits;

  assign off         = sr.rx.addr - BASE_ADDR;
  assign in_win      = sr.rx.valid && (off < WIN_SIZE);
  assign req_rd      = in_win && !sr.rx.is_write;
  assign req_wr      = in_win && sr.rx.is_write;
  assign ch          = off[CH_W+1:2];
  assign reg_sel     = off[1:0];
  assign unused_bits = ^{off, sr.rx.data};

  logic [CNT_W-1:0]      h2r_count [NUM_CH];
  logic [CNT_W-1:0]      r2h_count [NUM_CH];
  logic [DATA_WIDTH-1:0] h2r_dout  [NUM_CH];
  logic [R2H_W-1:0]      r2h_dout  [NUM_CH];
  logic [7:0]            ovf_count [NUM_CH];
  logic [NUM_CH-1:0]     h2r_empty;
  logic [NUM_CH-1:0]     h2r_full;
  logic [NUM_CH-1:0]     r2h_empty;
  logic [NUM_CH-1:0]     r2h_full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic             h2r_wr;
    logic             r2h_rd;
    logic             ctrl_wr;
    logic             flush;
    logic             ovf_clr;
    logic [R2H_W-1:0] r2h_din;

    assign sel     = (ch == CH_W'(c));
    assign h2r_wr  = req_wr && sel && (reg_sel == REG_DATA);
    assign ctrl_wr = req_wr && sel && (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr && sr.rx.data[CTRL_FLUSH_BIT];
    assign ovf_clr = ctrl_wr && sr.rx.data[CTRL_CLR_OVF_BIT];
    assign r2h_rd  = req_rd && sel && (reg_sel == REG_DATA);

`ifdef TACC_MAILBOX_TIMESTAMP_EN
    assign r2h_din = {ts_cnt, to_host_data[c*DATA_WIDTH +: DATA_WIDTH]};
`else
    assign r2h_din = to_host_data[c*DATA_WIDTH +: DATA_WIDTH];
`endif

    tacc_sync_fifo #(
      .WIDTH      (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_h2r (
      .clk   (clk),
      .rst   (rst),
      .wr    (h2r_wr),
      .rd    (from_host_ready[c]),
      .flush (flush),
      .din   (sr.rx.data[DATA_WIDTH-1:0]),
      .dout  (h2r_dout[c]),
      .empty (h2r_empty[c]),
      .full  (h2r_full[c]),
      .count (h2r_count[c])
    );

    // Flush beats a same-cycle role push; the push is simply lost
    tacc_sync_fifo #(
      .WIDTH      (R2H_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_r2h (
      .clk   (clk),
      .rst   (rst),
      .wr    (to_host_valid[c]),
      .rd    (r2h_rd),
      .flush (flush),
      .din   (r2h_din),
      .dout  (r2h_dout[c]),
      .empty (r2h_empty[c]),
      .full  (r2h_full[c]),
      .count (r2h_count[c])
    );

    // Host writes that hit a full host->role FIFO are dropped and counted
    always_ff @(posedge clk) begin
      if (rst)                        ovf_count[c] <= '0;
      else if (ovf_clr)               ovf_count[c] <= '0;
      else if (h2r_wr && h2r_full[c]) ovf_count[c] <= sat_inc8(ovf_count[c]);
    end

    assign to_host_ready[c]                                  = !r2h_full[c];
    assign from_host_valid[c]                                = !h2r_empty[c];
    assign from_host_data[c*DATA_WIDTH +: DATA_WIDTH]        = h2r_dout[c];
    assign irq_pending[c]                                    = !r2h_empty[c];
  end

  // Read data is formed in the request cycle, while the popped word is
  // still at the FIFO head.
  logic [63:0]      rd_data;
  logic [R2H_W-1:0] head;
  status_t          status;

  always_comb begin
    rd_data          = '0;
    head             = r2h_dout[ch];
    status           = '0;
    status.r2h_occ   = 16'(r2h_count[ch]);
    status.h2r_occ   = 16'(h2r_count[ch]);
    status.ovf_count = ovf_count[ch];
    status.h2r_full  = h2r_full[ch];
    status.r2h_empty = r2h_empty[ch];
    case (reg_sel)
      REG_DATA: begin
        if (r2h_empty[ch]) begin
          rd_data = EMPTY_CODE;
        end else begin
`ifdef TACC_MAILBOX_TIMESTAMP_EN
          rd_data = {head[R2H_W-1 -: TS_WIDTH], 32'(head[DATA_WIDTH-1:0])};
`else
          rd_data = 64'(head);
`endif
        end
      end
      REG_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

  // Two-stage response pipeline: request at N, tx.valid at N+2
  logic          s1_valid;
  logic [63:0]   s1_data;
  softreg_resp_t tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      tx_q      <= '0;
    end else begin
      s1_valid  <= req_rd;
      s1_data   <= rd_data;
      tx_q.valid <= s1_valid;
      tx_q.data  <= s1_valid ? s1_data : '0;
    end
  end

  assign sr.tx = tx_q;

endmodule

// File: tb/tb_tacc_softreg_mailbox.sv
// tb_tacc_softreg_mailbox
//   Directed bench for tacc_softreg_mailbox with a response scoreboard.
//   Reads push their expected word and due cycle into a queue; a monitor on
//   the falling edge pops and compares each tx.valid response.
module tb_tacc_softreg_mailbox;
  import tacc_mailbox_pkg::*;

  localparam int          NUM_CH     = 4;
  localparam int          DW         = 8;
  localparam int          DEPTH_LOG2 = 5;
  localparam logic [31:0] BASE       = 32'd1234;
  localparam logic [63:0] EMPTY      = 64'd110000;
  localparam logic [63:0] ALL        = '1;
`ifdef TACC_MAILBOX_TIMESTAMP_EN
  localparam logic [63:0] DMASK      = 64'h0000_0000_FFFF_FFFF;
`else
  localparam logic [63:0] DMASK      = '1;
`endif

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    int          due;
    string       name;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    to_host_valid;
  logic [NUM_CH-1:0]    to_host_ready;
  logic [NUM_CH*DW-1:0] to_host_data;
  logic [NUM_CH-1:0]    from_host_valid;
  logic [NUM_CH-1:0]    from_host_ready;
  logic [NUM_CH*DW-1:0] from_host_data;
  logic [NUM_CH-1:0]    irq_pending;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   tx_count = 0;
  exp_t sb_q[$];

  tacc_softreg_mailbox_if sr();

  tacc_softreg_mailbox #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE),
    .EMPTY_CODE (EMPTY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sr              (sr),
    .to_host_valid   (to_host_valid),
    .to_host_ready   (to_host_ready),
    .to_host_data    (to_host_data),
    .from_host_valid (from_host_valid),
    .from_host_ready (from_host_ready),
    .from_host_data  (from_host_data),
    .irq_pending     (irq_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef TACC_MAILBOX_TIMESTAMP_EN
  int ts_model = 0;
  always @(posedge clk) begin
    if (rst) ts_model <= 0;
    else     ts_model <= ts_model + 1;
  end
`endif

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (sr.tx.valid) begin
      tx_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_resp: got 0x%0h at cycle %0d, expected no response", sr.tx.data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (((sr.tx.data & e.mask) != (e.data & e.mask)) || (cyc != e.due)) begin
          failures++;
          $display("[TB] FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                   e.name, sr.tx.data, cyc, e.data, e.due);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no response, expected 0x%0h at cycle %0d", e.name, e.data, e.due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one SoftReg request for exactly one cycle
  task automatic applyStimulus(input logic is_write, input logic [31:0] addr, input logic [63:0] data);
    sr.rx.valid    = 1'b1;
    sr.rx.is_write = is_write;
    sr.rx.addr     = addr;
    sr.rx.data     = data;
    tick();
    sr.rx.valid    = 1'b0;
  endtask

  task automatic hostRead(input logic [31:0] addr, input logic [63:0] expd,
                          input logic [63:0] mask, input string name);
    exp_t e;
    e.data = expd;
    e.mask = mask;
    e.due  = cyc + 2;
    e.name = name;
    sb_q.push_back(e);
    applyStimulus(1'b0, addr, 64'd0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int snap;
    rst             = 1'b1;
    sr.rx           = '0;
    to_host_valid   = '0;
    to_host_data    = '0;
    from_host_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_tx_valid", 64'(sr.tx.valid), 64'd0);
    checkOutput("rst_tx_data", sr.tx.data, 64'd0);
    checkOutput("rst_to_host_ready", 64'(to_host_ready), 64'hF);
    checkOutput("rst_from_host_valid", 64'(from_host_valid), 64'd0);
    checkOutput("rst_irq_pending", 64'(irq_pending), 64'd0);

    $display("[TB] host write ch0");
    applyStimulus(1'b1, BASE + 0, 64'h5A);
    checkOutput("ch0_from_host_valid", 64'(from_host_valid[0]), 64'd1);
    checkOutput("ch0_from_host_data", 64'(from_host_data[7:0]), 64'h5A);
    hostRead(BASE + 1, 64'h0000_0200_0001_0000, ALL, "ch0_status");
    from_host_ready[0] = 1'b1;
    tick();
    from_host_ready[0] = 1'b0;
    checkOutput("ch0_popped", 64'(from_host_valid[0]), 64'd0);

    $display("[TB] role push ch2, host reads");
    to_host_valid[2]      = 1'b1;
    to_host_data[23:16]   = 8'h11;
    tick();
    to_host_data[23:16]   = 8'h22;
    tick();
    to_host_valid[2]      = 1'b0;
    checkOutput("ch2_irq_set", 64'(irq_pending[2]), 64'd1);
    hostRead(BASE + 8, 64'h11, DMASK, "ch2_read0");
    hostRead(BASE + 8, 64'h22, DMASK, "ch2_read1");
    hostRead(BASE + 8, EMPTY, ALL, "ch2_read_empty");
    checkOutput("ch2_irq_clear", 64'(irq_pending[2]), 64'd0);

    $display("[TB] ch1 overflow");
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, BASE + 4, 64'(i));
    checkOutput("ch1_head", 64'(from_host_data[15:8]), 64'd0);
    hostRead(BASE + 5, 64'h0000_0301_0020_0000, ALL, "ch1_status_ovf");
    applyStimulus(1'b1, BASE + 6, 64'd2);
    hostRead(BASE + 5, 64'h0000_0300_0020_0000, ALL, "ch1_status_clr");
    from_host_ready[1] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checkOutput("ch1_order", 64'(from_host_data[15:8]), 64'(i));
      tick();
    end
    from_host_ready[1] = 1'b0;
    checkOutput("ch1_drained", 64'(from_host_valid[1]), 64'd0);

    $display("[TB] ch0 full with simultaneous push and pop");
    to_host_valid[0] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      to_host_data[7:0] = 8'(8'h40 + i);
      tick();
    end
    checkOutput("ch0_ready_full", 64'(to_host_ready[0]), 64'd0);
    to_host_data[7:0] = 8'hEE;
    hostRead(BASE + 0, 64'h40, DMASK, "ch0_pop_full");
    checkOutput("ch0_ready_after_pop", 64'(to_host_ready[0]), 64'd1);
    tick();
    to_host_valid[0] = 1'b0;
    hostRead(BASE + 1, 64'h20, ALL, "ch0_status_full");
    for (int i = 0; i < 32; i++)
      hostRead(BASE + 0, (i < 31) ? 64'(8'h41 + i) : 64'hEE, DMASK, "ch0_drain");

    $display("[TB] ch3 flush");
    to_host_valid[3]    = 1'b1;
    to_host_data[31:24] = 8'h44;
    applyStimulus(1'b1, BASE + 12, 64'h33);
    checkOutput("ch3_pre_irq", 64'(irq_pending[3]), 64'd1);
    checkOutput("ch3_pre_valid", 64'(from_host_valid[3]), 64'd1);
    to_host_data[31:24] = 8'h55;
    applyStimulus(1'b1, BASE + 14, 64'd1);
    to_host_valid[3]    = 1'b0;
    checkOutput("ch3_flush_valid", 64'(from_host_valid[3]), 64'd0);
    checkOutput("ch3_flush_irq", 64'(irq_pending[3]), 64'd0);
    checkOutput("ch3_flush_ready", 64'(to_host_ready[3]), 64'd1);
    hostRead(BASE + 12, EMPTY, ALL, "ch3_read_empty");
    hostRead(BASE + 13, 64'h0000_0200_0000_0000, ALL, "ch3_status");

    $display("[TB] ctrl/reserved reads and out-of-window");
    hostRead(BASE + 2, 64'd0, ALL, "ctrl_read");
    hostRead(BASE + 3, 64'd0, ALL, "rsvd_read");
    repeat (3) tick();
    snap = tx_count;
    applyStimulus(1'b0, BASE + 16, 64'd0);
    applyStimulus(1'b0, BASE - 1, 64'd0);
    repeat (5) tick();
    checkOutput("out_of_window", 64'(tx_count - snap), 64'd0);

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, BASE + 0, 64'h99);
    snap = tx_count;
    applyStimulus(1'b0, BASE + 1, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("reset_cancel", 64'(tx_count - snap), 64'd0);
    checkOutput("reset_lost", 64'(from_host_valid), 64'd0);

`ifdef TACC_MAILBOX_TIMESTAMP_EN
    $display("[TB] timestamp");
    for (int i = 0; i < 200 && ts_model < 100; i++) tick();
    checkOutput("ts_cycle", 64'(ts_model), 64'd100);
    to_host_valid[1]   = 1'b1;
    to_host_data[15:8] = 8'h77;
    tick();
    to_host_valid[1]   = 1'b0;
    hostRead(BASE + 4, {32'd100, 32'h77}, ALL, "ts_read");
`endif

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
